cr_rbus_ring_master: RTL and testbench

//  Initiator end of the rbus register ring. Accepts one host register read or write and injects it at the ring head.

---
 rtl/cr_rbus_ring_master_pkg.sv | 32 +++
 rtl/cr_rbus_ring_master.sv | 160 ++++++++++++++++
 tb/tb_cr_rbus_ring_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cr_rbus_ring_master_pkg.sv
// cr_rbus_ring_master_pkg
//   Shared types for the rbus ring master: ring payload struct, bus widths,
//   FSM state encoding and response status codes.
package cr_rbus_ring_master_pkg;

    localparam int N_RBUS_ADDR_BITS = 16;
    localparam int N_RBUS_DATA_BITS = 32;

    typedef struct packed {
        logic [N_RBUS_ADDR_BITS-1:0] addr;
        logic                        wr_strb;
        logic [N_RBUS_DATA_BITS-1:0] wr_data;
        logic                        rd_strb;
        logic [N_RBUS_DATA_BITS-1:0] rd_data;
        logic                        ack;
        logic                        err_ack;
    } rbus_ring_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rbus_mst_state_e;

    typedef enum logic [1:0] {
        OK      = 2'd0,
        SLV_ERR = 2'd1,
        TIMEOUT = 2'd2
    } rbus_resp_err_e;

endpackage

// File: rtl/cr_rbus_ring_master.sv
// cr_rbus_ring_master
//   Initiator at the head of the rbus register ring. Takes one host read or
//   write, puts it on the ring, waits for the matching ack/err_ack at the ring
//   tail (or a timeout) and returns data and status to the host.
//   The ring terminates here; rbus_ring_i is never forwarded.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      host request handshake (req_wr, req_addr, req_wdata)
//   resp_valid/resp_ready    host response handshake (resp_rdata, resp_err)
//   rbus_ring_o              ring head
//   rbus_ring_i              ring tail
//   stat_timeout             one-cycle pulse per timeout completion
//
// State | Meaning
// IDLE  | ready for a host request
// ISSUE | strobe on the ring head for one cycle
// WAIT  | waiting for matching ack/err_ack, timeout counter running
// RESP  | response presented until the host takes it
module cr_rbus_ring_master
    import cr_rbus_ring_master_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_wr,
    input  logic [N_RBUS_ADDR_BITS-1:0] req_addr,
    input  logic [N_RBUS_DATA_BITS-1:0] req_wdata,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [N_RBUS_DATA_BITS-1:0] resp_rdata,
    output logic [1:0]                  resp_err,
    output rbus_ring_t                  rbus_ring_o,
    input  rbus_ring_t                  rbus_ring_i,
    output logic                        stat_timeout
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    rbus_mst_state_e             state, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        wr_q;
    logic [N_RBUS_ADDR_BITS-1:0] addr_q;

    logic                        req_ready_d;
    logic                        resp_valid_d;
    logic [N_RBUS_DATA_BITS-1:0] resp_rdata_d;
    logic [1:0]                  resp_err_d;
    logic                        stat_timeout_d;
    rbus_ring_t                  ring_d;

    logic hs;
    logic ring_hit;
    logic match;
    logic timeout_hit;

    // Ring slaves never drive these fields back toward the master.
    logic unused_ring_fields;
    assign unused_ring_fields = ^{rbus_ring_i.wr_strb, rbus_ring_i.wr_data, rbus_ring_i.rd_strb};

    assign hs          = req_valid && req_ready;
    assign ring_hit    = (rbus_ring_i.addr == addr_q) && (rbus_ring_i.ack || rbus_ring_i.err_ack);
    assign match       = (state == WAIT) && ring_hit;
    // A match in the terminal-count cycle takes priority over the timeout.
    assign timeout_hit = (state == WAIT) && !ring_hit && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt_q        <= '0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            req_ready    <= 1'b0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= OK;
            stat_timeout <= 1'b0;
            rbus_ring_o  <= '0;
        end else begin
            state        <= state_d;
            cnt_q        <= cnt_d;
            if (hs) begin
                wr_q   <= req_wr;
                addr_q <= req_addr;
            end
            req_ready    <= req_ready_d;
            resp_valid   <= resp_valid_d;
            resp_rdata   <= resp_rdata_d;
            resp_err     <= resp_err_d;
            stat_timeout <= stat_timeout_d;
            rbus_ring_o  <= ring_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (hs) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (match || timeout_hit) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered, so they are computed here from the state being
    // entered; this puts the strobe on the ring in the cycle after the handshake.
    always_comb begin
        cnt_d          = '0;
        ring_d         = '0;
        resp_rdata_d   = resp_rdata;
        resp_err_d     = resp_err;
        stat_timeout_d = 1'b0;

        if (state == WAIT) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        if (state_d != IDLE) begin
            ring_d.addr = (state == IDLE) ? req_addr : addr_q;
        end
        if (state == IDLE && hs) begin
            ring_d.wr_strb = req_wr;
            ring_d.rd_strb = !req_wr;
            ring_d.wr_data = req_wr ? req_wdata : '0;
        end

        case (state)
            WAIT: begin
                if (match) begin
                    resp_err_d   = rbus_ring_i.err_ack ? SLV_ERR : OK;
                    resp_rdata_d = (rbus_ring_i.ack && !rbus_ring_i.err_ack && !wr_q)
                                   ? rbus_ring_i.rd_data : '0;
                end else if (timeout_hit) begin
                    resp_err_d     = TIMEOUT;
                    resp_rdata_d   = '0;
                    stat_timeout_d = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_err_d   = OK;
                    resp_rdata_d = '0;
                end
            end
            default: begin
                resp_err_d   = OK;
                resp_rdata_d = '0;
            end
        endcase

        resp_valid_d = (state_d == RESP);
        req_ready_d  = (state_d == IDLE);
    end

endmodule

// File: tb/tb_cr_rbus_ring_master.sv
module tb_cr_rbus_ring_master;
    import cr_rbus_ring_master_pkg::*;

    localparam int T = 16;
    localparam int A = N_RBUS_ADDR_BITS;
    localparam int D = N_RBUS_DATA_BITS;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready, req_wr;
    logic [A-1:0] req_addr;
    logic [D-1:0] req_wdata;
    logic         resp_valid, resp_ready;
    logic [D-1:0] resp_rdata;
    logic [1:0]   resp_err;
    rbus_ring_t   rbus_ring_o, rbus_ring_i;
    logic         stat_timeout;

    int checks = 0;
    int errors = 0;

    cr_rbus_ring_master #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .rbus_ring_o(rbus_ring_o), .rbus_ring_i(rbus_ring_i),
        .stat_timeout(stat_timeout)
    );

    always #5 clk = ~clk;

    // Present a request at a negedge; returns at the negedge of the strobe cycle.
    task automatic send_req(input logic wr, input logic [A-1:0] a, input logic [D-1:0] wd, output bit ok);
        req_wr = wr; req_addr = a; req_wdata = wd; req_valid = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
    endtask

    // Slave stand-in: k counts negedges from the strobe cycle (k=0). The real
    // ack is driven at k==d (d<0: never), a wrong-address ack at k==bd.
    // Returns the k at which resp_valid is first seen (-1 if never).
    task automatic wait_resp(input int d, input logic ak, input logic ek, input logic [A-1:0] a,
                             input logic [D-1:0] rd, input int bd,
                             output int lat, output int to_cnt, output int wr_cnt, output int rd_cnt);
        lat = -1; to_cnt = 0; wr_cnt = 0; rd_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            to_cnt += stat_timeout ? 1 : 0;
            wr_cnt += rbus_ring_o.wr_strb ? 1 : 0;
            rd_cnt += rbus_ring_o.rd_strb ? 1 : 0;
            if (resp_valid === 1'b1) begin
                lat = k;
                break;
            end
            rbus_ring_i = '0;
            if (k == d) begin
                rbus_ring_i.addr = a; rbus_ring_i.ack = ak; rbus_ring_i.err_ack = ek;
                rbus_ring_i.rd_data = rd;
            end else if (k == bd) begin
                rbus_ring_i.addr = a ^ 16'h0004; rbus_ring_i.ack = 1'b1; rbus_ring_i.rd_data = ~rd;
            end
            @(negedge clk);
        end
        rbus_ring_i = '0;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b0; rbus_ring_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_rdata, resp_err, stat_timeout} !== '0)
            begin errors++; $display("FAIL reset_outputs got rdy=%b vld=%b rd=%h err=%0d to=%b exp all 0",
                  req_ready, resp_valid, resp_rdata, resp_err, stat_timeout); end
        checks++;
        if (rbus_ring_o !== '0) begin errors++; $display("FAIL reset_ring got %h exp 0", rbus_ring_o); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got %b exp 1", req_ready); end
    endtask

    task automatic test_write();
        bit ok; int lat, to, wc, rc;
        send_req(1'b1, 16'h0100, 32'hDEAD_BEEF, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL write_handshake got none exp accept"); end
        checks++;
        if (rbus_ring_o.wr_strb !== 1'b1 || rbus_ring_o.rd_strb !== 1'b0 ||
            rbus_ring_o.addr !== 16'h0100 || rbus_ring_o.wr_data !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL write_issue got wr=%b rd=%b a=%h d=%h exp 1 0 0100 deadbeef",
                  rbus_ring_o.wr_strb, rbus_ring_o.rd_strb, rbus_ring_o.addr, rbus_ring_o.wr_data); end
        wait_resp(5, 1'b1, 1'b0, 16'h0100, 32'h5555_AAAA, -1, lat, to, wc, rc);
        checks++;
        if (lat != 6) begin errors++; $display("FAIL write_latency got %0d exp 6", lat); end
        checks++;
        if (wc != 1 || rc != 0) begin errors++; $display("FAIL write_strobes got wr=%0d rd=%0d exp 1 0", wc, rc); end
        checks++;
        if (resp_err !== 2'd0 || resp_rdata !== '0)
            begin errors++; $display("FAIL write_resp got err=%0d rd=%h exp 0 0", resp_err, resp_rdata); end
        checks++;
        if (rbus_ring_o.addr !== 16'h0100) begin errors++; $display("FAIL write_addr_held got %h exp 0100", rbus_ring_o.addr); end
        finish_resp();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || rbus_ring_o !== '0)
            begin errors++; $display("FAIL write_to_idle got vld=%b rdy=%b ring=%h exp 0 1 0",
                  resp_valid, req_ready, rbus_ring_o); end
    endtask

    task automatic test_read();
        bit ok; int lat, to, wc, rc;
        send_req(1'b0, 16'h0200, 32'hFFFF_FFFF, ok);
        checks++;
        if (!ok || rbus_ring_o.rd_strb !== 1'b1 || rbus_ring_o.wr_strb !== 1'b0 || rbus_ring_o.wr_data !== '0)
            begin errors++; $display("FAIL read_issue got ok=%b rd=%b wr=%b d=%h exp 1 1 0 0",
                  ok, rbus_ring_o.rd_strb, rbus_ring_o.wr_strb, rbus_ring_o.wr_data); end
        wait_resp(3, 1'b1, 1'b0, 16'h0200, 32'h1234_5678, -1, lat, to, wc, rc);
        checks++;
        if (lat != 4 || rc != 1 || wc != 0)
            begin errors++; $display("FAIL read_timing got lat=%0d rd=%0d wr=%0d exp 4 1 0", lat, rc, wc); end
        checks++;
        if (resp_rdata !== 32'h1234_5678 || resp_err !== 2'd0)
            begin errors++; $display("FAIL read_resp got rd=%h err=%0d exp 12345678 0", resp_rdata, resp_err); end
        finish_resp();
    endtask

    task automatic test_timeout();
        bit ok; int lat, to, wc, rc;
        send_req(1'b0, 16'h0300, '0, ok);
        wait_resp(-1, 1'b0, 1'b0, 16'h0300, '0, -1, lat, to, wc, rc);
        checks++;
        if (!ok || lat != T + 1) begin errors++; $display("FAIL timeout_latency got %0d exp %0d", lat, T + 1); end
        checks++;
        if (resp_err !== 2'd2 || resp_rdata !== '0 || to != 1)
            begin errors++; $display("FAIL timeout_resp got err=%0d rd=%h pulses=%0d exp 2 0 1", resp_err, resp_rdata, to); end
        @(negedge clk);
        checks++;
        if (stat_timeout !== 1'b0 || resp_valid !== 1'b1)
            begin errors++; $display("FAIL timeout_pulse_len got to=%b vld=%b exp 0 1", stat_timeout, resp_valid); end
        finish_resp();
        rbus_ring_i = '0; rbus_ring_i.addr = 16'h0300; rbus_ring_i.ack = 1'b1; rbus_ring_i.rd_data = 32'hBAD0_BAD0;
        @(negedge clk);
        rbus_ring_i = '0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL late_ack_ignored got vld=%b rdy=%b exp 0 1", resp_valid, req_ready); end
        send_req(1'b1, 16'h0104, 32'h0000_0042, ok);
        wait_resp(2, 1'b1, 1'b0, 16'h0104, '0, -1, lat, to, wc, rc);
        checks++;
        if (!ok || lat != 3 || resp_err !== 2'd0 || to != 0)
            begin errors++; $display("FAIL post_timeout_write got lat=%0d err=%0d to=%0d exp 3 0 0", lat, resp_err, to); end
        finish_resp();
    endtask

    task automatic test_wrong_addr();
        bit ok; int lat, to, wc, rc;
        send_req(1'b0, 16'h0200, '0, ok);
        wait_resp(6, 1'b1, 1'b0, 16'h0200, 32'hCAFE_0001, 2, lat, to, wc, rc);
        checks++;
        if (!ok || lat != 7 || resp_rdata !== 32'hCAFE_0001)
            begin errors++; $display("FAIL wrong_addr got lat=%0d rd=%h exp 7 cafe0001", lat, resp_rdata); end
        finish_resp();
    endtask

    task automatic test_err_hold();
        bit ok; int lat, to, wc, rc, bad;
        send_req(1'b1, 16'h0180, 32'h0BAD_F00D, ok);
        wait_resp(4, 1'b0, 1'b1, 16'h0180, 32'h7777_7777, -1, lat, to, wc, rc);
        checks++;
        if (!ok || lat != 5 || resp_err !== 2'd1)
            begin errors++; $display("FAIL err_ack got lat=%0d err=%0d exp 5 1", lat, resp_err); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (resp_valid !== 1'b1 || resp_err !== 2'd1 || resp_rdata !== '0 || req_ready !== 1'b0 ||
                rbus_ring_o.addr !== 16'h0180) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL err_hold_stable got %0d unstable cycles exp 0", bad); end
        finish_resp();
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        send_req(1'b0, 16'h0208, '0, ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (rbus_ring_o !== '0 || resp_valid !== 1'b0 || req_ready !== 1'b0)
            begin errors++; $display("FAIL reset_in_wait got ring=%h vld=%b rdy=%b exp 0 0 0",
                  rbus_ring_o, resp_valid, req_ready); end
        rst = 1'b0;
        rbus_ring_i = '0; rbus_ring_i.addr = 16'h0208; rbus_ring_i.ack = 1'b1; rbus_ring_i.rd_data = 32'h1111_2222;
        @(negedge clk);
        rbus_ring_i = '0;
        @(negedge clk);
        checks++;
        if (!ok || resp_valid !== 1'b0 || req_ready !== 1'b1)
            begin errors++; $display("FAIL reset_drop_ack got vld=%b rdy=%b exp 0 1", resp_valid, req_ready); end
    endtask

    // Transaction-level model: an ack arriving d cycles after the strobe
    // completes the transfer if d <= T, otherwise the transfer times out T
    // cycles after WAIT entry; the response shows one cycle later.
    task automatic test_random();
        bit ok; int lat, to, wc, rc;
        int d, bd, kind, exp_lat, exp_err, exp_to;
        logic wr, ak, ek;
        logic [A-1:0] a;
        logic [D-1:0] wd, rd, exp_rd;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom); a = A'($urandom); wd = $urandom; rd = $urandom;
            d = $urandom_range(1, T + 4);
            bd = ($urandom_range(0, 1) == 1 && d > 1) ? $urandom_range(1, d - 1) : -1;
            kind = $urandom_range(0, 2);
            ak = (kind != 1); ek = (kind != 0);
            exp_lat = (d <= T) ? d + 1 : T + 1;
            exp_err = (d <= T) ? (ek ? 1 : 0) : 2;
            exp_rd  = (d <= T && ak && !ek && !wr) ? rd : '0;
            exp_to  = (d <= T) ? 0 : 1;
            send_req(wr, a, wd, ok);
            checks++;
            if (!ok || rbus_ring_o.addr !== a || rbus_ring_o.wr_data !== (wr ? wd : '0))
                begin errors++; $display("FAIL rnd_issue[%0d] got a=%h d=%h exp %h %h",
                      n, rbus_ring_o.addr, rbus_ring_o.wr_data, a, wr ? wd : '0); end
            wait_resp(d, ak, ek, a, rd, bd, lat, to, wc, rc);
            checks++;
            if (lat != exp_lat || to != exp_to || wc != int'(wr) || rc != int'(!wr))
                begin errors++; $display("FAIL rnd_timing[%0d] got lat=%0d to=%0d wr=%0d rd=%0d exp %0d %0d %0d %0d",
                      n, lat, to, wc, rc, exp_lat, exp_to, int'(wr), int'(!wr)); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== 2'(exp_err) || resp_rdata !== exp_rd)
                begin errors++; $display("FAIL rnd_resp[%0d] got vld=%b err=%0d rd=%h exp 1 %0d %h",
                      n, resp_valid, resp_err, resp_rdata, exp_err, exp_rd); end
            finish_resp();
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_wrong_addr();
        test_err_hold();
        test_reset_in_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got no finish exp finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
